// File: rtl/jpeg_dqt_loader_if.sv
// rtl/jpeg_dqt_loader_if.sv - byte stream with valid/data/last/accept handshake
interface jpeg_dqt_loader_if;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       accept;

    modport master (output valid, output data, output last, input accept);
    modport slave  (input valid, input data, input last, output accept);
endinterface

// File: rtl/jpeg_dqt_loader.sv
// rtl/jpeg_dqt_loader.sv - DQT segment parser feeding quantisation tables to the dequantiser cfg port
// Optional JPEG_DQT_LOADER_16BIT_EN: accept Pq=1 tables, saturating each 16-bit entry to 8 bits.
module jpeg_dqt_loader #(
    parameter logic [7:0] PAD_VALUE = 8'd1,
    parameter bit         ZERO_FIX  = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              img_start_i,
    input  logic              seg_start_i,
    jpeg_dqt_loader_if.slave  inport,
    jpeg_dqt_loader_if.master cfg,
    output logic [3:0]        table_loaded_o,
    output logic              busy_o,
    output logic              err_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_PQTQ, S_DATA, S_PAD, S_SKIP
    } state_t;

    localparam logic [7:0] PAD_ENTRY = (ZERO_FIX && PAD_VALUE == 8'd0) ? 8'd1 : PAD_VALUE;

    state_t      state_q;
    logic [7:0]  len_hi_q;
    logic [15:0] rem_q;
    logic [5:0]  cnt_q;
    logic [7:0]  skip_q;
    logic [1:0]  tq_q;
    logic        cfg_valid_q;
    logic [7:0]  cfg_data_q;
    logic        cfg_last_q;
    logic [3:0]  loaded_q;
    logic        err_q;
`ifdef JPEG_DQT_LOADER_16BIT_EN
    logic        wide_q;
    logic        lo_phase_q;
    logic [7:0]  hi_q;
`endif

    logic        out_ready;
    logic        consume;
    logic        seg_end;
    logic        pqtq_bad;
    logic        entry_strobe;
    logic [15:0] rem_dec;
    logic [15:0] lq_val;
    logic [7:0]  entry_val;

    assign out_ready = !cfg_valid_q || cfg.accept;
    assign consume   = inport.valid && inport.accept;
    assign rem_dec   = rem_q - 16'd1;
    assign lq_val    = {len_hi_q, inport.data};
    // The byte being consumed is the last one this segment will deliver.
    assign seg_end   = inport.last || (rem_dec == 16'd0);

`ifdef JPEG_DQT_LOADER_16BIT_EN
    assign pqtq_bad = (inport.data[3:0] > 4'd3) || (inport.data[7:4] > 4'd1);
`else
    assign pqtq_bad = (inport.data[3:0] > 4'd3) || (inport.data[7:4] != 4'd0);
`endif

    always_comb begin
        inport.accept = 1'b0;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_SKIP: inport.accept = 1'b1;
            S_PQTQ, S_DATA:             inport.accept = out_ready;
            default:                    inport.accept = 1'b0;
        endcase
    end

    // Wide entries only produce a cfg beat on the low byte of each pair.
    always_comb begin
        entry_val    = inport.data;
        entry_strobe = 1'b1;
`ifdef JPEG_DQT_LOADER_16BIT_EN
        if (wide_q) begin
            entry_strobe = lo_phase_q;
            if (hi_q != 8'd0) entry_val = 8'hFF;
        end
`endif
        if (ZERO_FIX && entry_val == 8'd0) entry_val = 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            len_hi_q    <= 8'd0;
            rem_q       <= 16'd0;
            cnt_q       <= 6'd0;
            skip_q      <= 8'd0;
            tq_q        <= 2'd0;
            cfg_valid_q <= 1'b0;
            cfg_data_q  <= 8'd0;
            cfg_last_q  <= 1'b0;
            loaded_q    <= 4'd0;
            err_q       <= 1'b0;
`ifdef JPEG_DQT_LOADER_16BIT_EN
            wide_q      <= 1'b0;
            lo_phase_q  <= 1'b0;
            hi_q        <= 8'd0;
`endif
        end else begin
            if (out_ready) cfg_valid_q <= 1'b0;
            // Clears first so that a completion or error later in this block wins.
            if (img_start_i) begin
                loaded_q <= 4'd0;
                err_q    <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (seg_start_i) state_q <= S_LEN_HI;
                end

                S_LEN_HI: begin
                    if (consume) begin
                        len_hi_q <= inport.data;
                        if (inport.last) begin
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_LEN_LO;
                        end
                    end
                end

                S_LEN_LO: begin
                    if (consume) begin
                        if (inport.last || lq_val < 16'd3) begin
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            rem_q   <= lq_val - 16'd2;
                            state_q <= S_PQTQ;
                        end
                    end
                end

                S_PQTQ: begin
                    if (consume) begin
                        rem_q <= rem_dec;
                        tq_q  <= inport.data[1:0];
                        if (seg_end) begin
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else if (pqtq_bad) begin
                            err_q   <= 1'b1;
                            skip_q  <= (inport.data[7:4] == 4'd1) ? 8'd128 : 8'd64;
                            state_q <= S_SKIP;
                        end else begin
                            cfg_valid_q <= 1'b1;
                            cfg_data_q  <= {6'd0, inport.data[1:0]};
                            cfg_last_q  <= 1'b0;
                            cnt_q       <= 6'd0;
`ifdef JPEG_DQT_LOADER_16BIT_EN
                            wide_q      <= inport.data[4];
                            lo_phase_q  <= 1'b0;
`endif
                            state_q     <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (consume) begin
                        rem_q <= rem_dec;
                        if (!entry_strobe) begin
`ifdef JPEG_DQT_LOADER_16BIT_EN
                            hi_q       <= inport.data;
                            lo_phase_q <= 1'b1;
`endif
                            if (seg_end) begin
                                err_q   <= 1'b1;
                                state_q <= S_PAD;
                            end
                        end else begin
`ifdef JPEG_DQT_LOADER_16BIT_EN
                            lo_phase_q <= 1'b0;
`endif
                            cfg_valid_q <= 1'b1;
                            cfg_data_q  <= entry_val;
                            cfg_last_q  <= (cnt_q == 6'd63);
                            cnt_q       <= cnt_q + 6'd1;
                            if (cnt_q == 6'd63) begin
                                loaded_q[tq_q] <= 1'b1;
                                if (rem_dec == 16'd0) begin
                                    state_q <= S_IDLE;
                                end else if (inport.last) begin
                                    err_q   <= 1'b1;
                                    state_q <= S_IDLE;
                                end else begin
                                    state_q <= S_PQTQ;
                                end
                            end else if (seg_end) begin
                                err_q   <= 1'b1;
                                state_q <= S_PAD;
                            end
                        end
                    end
                end

                // Fill the rest of a truncated table so the dequantiser index stays aligned.
                S_PAD: begin
                    if (out_ready) begin
                        cfg_valid_q <= 1'b1;
                        cfg_data_q  <= PAD_ENTRY;
                        cfg_last_q  <= (cnt_q == 6'd63);
                        cnt_q       <= cnt_q + 6'd1;
                        if (cnt_q == 6'd63) state_q <= S_IDLE;
                    end
                end

                S_SKIP: begin
                    if (consume) begin
                        rem_q  <= rem_dec;
                        skip_q <= skip_q - 8'd1;
                        if (skip_q == 8'd1) begin
                            if (rem_dec == 16'd0) begin
                                state_q <= S_IDLE;
                            end else if (inport.last) begin
                                err_q   <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                state_q <= S_PQTQ;
                            end
                        end else if (seg_end) begin
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cfg.valid      = cfg_valid_q;
    assign cfg.data       = cfg_data_q;
    assign cfg.last       = cfg_last_q;
    assign table_loaded_o = loaded_q;
    assign err_o          = err_q;
    assign busy_o         = (state_q != S_IDLE) || cfg_valid_q;
endmodule

// File: tb/tb_jpeg_dqt_loader.sv
// tb/tb_jpeg_dqt_loader.sv - table-driven bench for jpeg_dqt_loader plus reset/img_start corner sequences
module tb_jpeg_dqt_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       img_start;
    logic       seg_start;
    logic [3:0] loaded;
    logic       busy;
    logic       err;

    jpeg_dqt_loader_if inp ();
    jpeg_dqt_loader_if cfg ();

    jpeg_dqt_loader dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .img_start_i    (img_start),
        .seg_start_i    (seg_start),
        .inport         (inp),
        .cfg            (cfg),
        .table_loaded_o (loaded),
        .busy_o         (busy),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] lq;
        int          ntab;
        logic [7:0]  pqtq0;
        logic [7:0]  pqtq1;
        logic [7:0]  base;
        int          n_send;
        bit          stall;
        bit          emit0;
        bit          emit1;
        int          n_real;
        bit          special;
        int          exp_beats;
        logic [3:0]  exp_loaded;
        bit          exp_err;
    } vec_t;

    int         n_chk  = 0;
    int         n_fail = 0;
    bit         stall_mode = 1'b0;
    logic [7:0] byte_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];

    always @(negedge clk) begin
        if (!rst && cfg.valid && cfg.accept) obs_q.push_back({cfg.last, cfg.data});
    end

    always @(posedge clk) begin
        #1;
        cfg.accept = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic build(input vec_t v);
        logic [7:0] pt;
        logic [7:0] val;
        logic [7:0] d;
        bit         emit;
        bit         wide;
        bit         sp;
        byte_q.delete();
        exp_q.delete();
        byte_q.push_back(v.lq[15:8]);
        byte_q.push_back(v.lq[7:0]);
        for (int t = 0; t < v.ntab; t++) begin
            pt   = (t == 0) ? v.pqtq0 : v.pqtq1;
            emit = (t == 0) ? v.emit0 : v.emit1;
            wide = (pt[7:4] == 4'd1);
            byte_q.push_back(pt);
            if (emit) exp_q.push_back({1'b0, 6'd0, pt[1:0]});
            for (int j = 0; j < 64; j++) begin
                val = v.base + 8'(j);
                sp  = v.special && (j == 4);
                if (wide) begin
                    byte_q.push_back(sp ? 8'h01 : 8'h00);
                    byte_q.push_back(sp ? 8'h23 : val);
                end else begin
                    byte_q.push_back(val);
                end
                d = sp ? 8'hFF : val;
                if (j >= v.n_real) d = 8'd1;
                if (d == 8'd0) d = 8'd1;
                if (emit) exp_q.push_back({(j == 63), d});
            end
        end
        while (byte_q.size() > 2 + v.n_send) void'(byte_q.pop_back());
    endtask

    task automatic pulse_seg();
        seg_start = 1'b1;
        @(posedge clk); #1;
        seg_start = 1'b0;
    endtask

    task automatic pulse_img();
        img_start = 1'b1;
        @(posedge clk); #1;
        img_start = 1'b0;
    endtask

    task automatic send(input int lo, input int hi, input bit do_last, input bit img_last);
        int n;
        bit got;
        for (int i = lo; i < hi; i++) begin
            inp.valid = 1'b1;
            inp.data  = byte_q[i];
            inp.last  = do_last && (i == hi - 1);
            img_start = img_last && (i == hi - 1);
            n   = 0;
            got = 1'b0;
            while (!got && n < 1000) begin
                @(negedge clk);
                if (inp.accept) got = 1'b1;
                else n++;
            end
            if (!got) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: byte %0d not accepted after %0d cycles", i, n);
                inp.valid = 1'b0;
                inp.last  = 1'b0;
                img_start = 1'b0;
                return;
            end
            @(posedge clk); #1;
            img_start = 1'b0;
        end
        inp.valid = 1'b0;
        inp.last  = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_idle_timeout: busy still 1 after %0d cycles, expected 0", nm, n);
        end
    endtask

    task automatic check_beats(input string nm, input int exp_n);
        chk({nm, "_beats"}, obs_q.size(), exp_n);
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            chk($sformatf("%s_beat%0d", nm, k), obs_q[k], exp_q[k]);
    endtask

    initial begin
        vec_t vecs[8];
        vec_t h;

        vecs[0] = '{"basic",    16'd67,  1, 8'h01, 8'h00, 8'd1, 65,  1'b0, 1'b1, 1'b0, 64, 1'b0, 65,  4'b0010, 1'b0};
        vecs[1] = '{"two_tab",  16'd132, 2, 8'h00, 8'h03, 8'd1, 130, 1'b1, 1'b1, 1'b1, 64, 1'b0, 130, 4'b1001, 1'b0};
        vecs[2] = '{"bad_tq",   16'd67,  1, 8'h05, 8'h00, 8'd1, 65,  1'b0, 1'b0, 1'b0, 64, 1'b0, 0,   4'b0000, 1'b1};
        vecs[3] = '{"trunc",    16'd67,  1, 8'h02, 8'h00, 8'd1, 11,  1'b1, 1'b1, 1'b0, 10, 1'b0, 65,  4'b0000, 1'b1};
        vecs[4] = '{"lq_short", 16'd2,   0, 8'h00, 8'h00, 8'd1, 0,   1'b0, 1'b0, 1'b0, 64, 1'b0, 0,   4'b0000, 1'b1};
        vecs[5] = '{"zero_fix", 16'd67,  1, 8'h00, 8'h00, 8'd0, 65,  1'b0, 1'b1, 1'b0, 64, 1'b0, 65,  4'b0001, 1'b0};
        vecs[6] = '{"excess",   16'd132, 1, 8'h03, 8'h00, 8'd1, 65,  1'b1, 1'b1, 1'b0, 64, 1'b0, 65,  4'b1000, 1'b1};
`ifdef JPEG_DQT_LOADER_16BIT_EN
        vecs[7] = '{"pq1",      16'd131, 1, 8'h10, 8'h00, 8'd1, 129, 1'b0, 1'b1, 1'b0, 64, 1'b1, 65,  4'b0001, 1'b0};
`else
        vecs[7] = '{"pq1",      16'd131, 1, 8'h10, 8'h00, 8'd1, 129, 1'b0, 1'b0, 1'b0, 64, 1'b1, 0,   4'b0000, 1'b1};
`endif

        rst        = 1'b1;
        img_start  = 1'b0;
        seg_start  = 1'b0;
        inp.valid  = 1'b0;
        inp.data   = 8'd0;
        inp.last   = 1'b0;
        cfg.accept = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg_valid", cfg.valid, 0);
        chk("rst_cfg_data", cfg.data, 0);
        chk("rst_cfg_last", cfg.last, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_accept", inp.accept, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            build(vecs[i]);
            stall_mode = vecs[i].stall;
            pulse_img();
            chk({vecs[i].name, "_clr"}, {err, loaded}, 5'd0);
            obs_q.delete();
            pulse_seg();
            send(0, byte_q.size(), 1'b1, 1'b0);
            wait_idle(vecs[i].name);
            check_beats(vecs[i].name, vecs[i].exp_beats);
            chk({vecs[i].name, "_loaded"}, loaded, vecs[i].exp_loaded);
            chk({vecs[i].name, "_err"}, err, vecs[i].exp_err);
        end
        stall_mode = 1'b0;

        // Reset in the middle of a table, then a clean full load.
        h = '{"rst_mid", 16'd67, 1, 8'h00, 8'h00, 8'd1, 65, 1'b0, 1'b1, 1'b0, 64, 1'b0, 65, 4'b0001, 1'b0};
        build(h);
        pulse_img();
        obs_q.delete();
        pulse_seg();
        send(0, 22, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_valid", cfg.valid, 0);
        chk("rst_mid_data", cfg.data, 0);
        chk("rst_mid_last", cfg.last, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_loaded", loaded, 0);
        chk("rst_mid_err", err, 0);
        chk("rst_mid_accept", inp.accept, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        obs_q.delete();
        pulse_seg();
        send(0, byte_q.size(), 1'b1, 1'b0);
        wait_idle("rst_load");
        check_beats("rst_load", 65);
        chk("rst_load_loaded", loaded, 4'b0001);
        chk("rst_load_err", err, 0);

        // img_start mid-table clears bit 0; the in-flight Tq=2 table still completes.
        h = '{"img_mid", 16'd67, 1, 8'h02, 8'h00, 8'd1, 65, 1'b0, 1'b1, 1'b0, 64, 1'b0, 65, 4'b0100, 1'b0};
        build(h);
        obs_q.delete();
        pulse_seg();
        send(0, 30, 1'b0, 1'b0);
        pulse_img();
        chk("img_mid_clr", {err, loaded}, 5'd0);
        send(30, byte_q.size(), 1'b1, 1'b0);
        wait_idle("img_mid");
        check_beats("img_mid", 65);
        chk("img_mid_loaded", loaded, 4'b0100);
        chk("img_mid_err", err, 0);

        // img_start in the same cycle as the 64th entry: bit 2 cleared, bit 3 set.
        h = '{"img_same", 16'd67, 1, 8'h03, 8'h00, 8'd1, 65, 1'b0, 1'b1, 1'b0, 64, 1'b0, 65, 4'b1000, 1'b0};
        build(h);
        obs_q.delete();
        pulse_seg();
        send(0, byte_q.size() - 1, 1'b0, 1'b0);
        send(byte_q.size() - 1, byte_q.size(), 1'b1, 1'b1);
        wait_idle("img_same");
        check_beats("img_same", 65);
        chk("img_same_loaded", loaded, 4'b1000);
        chk("img_same_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
